// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and bit-period math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Integer-truncated clock cycles per serial bit.
  function automatic int bit_cycles(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO, head visible combinationally; a full FIFO accepts a push only alongside a pop.
// Pops on an empty FIFO are ignored; occupancy is counted separately from the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       data,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & valid;
  // On a full FIFO the popped head slot is exactly the one being written.
  assign push_ok = push & (~full | pop_ok);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver_fifo.sv
// 8N1 UART receiver feeding a pop-side valid/ready FIFO; o_valid rises 1 cycle after the stop sample.
// Bytes arriving while the FIFO is full (and not popped that cycle) are dropped and flagged as overrun.
module uart_receiver_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        i_rx,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_overrun,
  output logic                        o_frame_err,
  input  logic                        i_clear_err,
  output logic                        o_busy
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W   = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC / 2 - 1);

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic [7:0]       push_data;
  logic             fifo_full;
  logic             fall;
  logic             sample;
  logic             pop_ok;

  // Flops preset to 1 so the line reads idle straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign sample = (baud_cnt == '0);
  assign o_busy = (state != IDLE);
  assign pop_ok = i_ready & o_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push        <= 1'b0;
      push_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      push     <= 1'b0;
      baud_cnt <= baud_cnt - 1'b1;
      if (i_clear_err) o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (sample) begin
            if (!rx_s) begin
              baud_cnt <= FULL_LOAD;
              bit_idx  <= '0;
              state    <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= FULL_LOAD;
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (rx_s) begin
              push      <= 1'b1;
              push_data <= shreg;
              state     <= IDLE;
            end else begin
              // Placed after the clear so a same-cycle set wins.
              o_frame_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_overrun <= 1'b0;
    end else if (push & fifo_full & ~pop_ok) begin
      o_overrun <= 1'b1;
    end else if (i_clear_err) begin
      o_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (i_ready),
    .data      (o_data),
    .valid     (o_valid),
    .full      (fifo_full),
    .count     (o_count)
  );

endmodule

// File: doc/uart_receiver_fifo.md
Name: uart_receiver_fifo

Overview:
- UART receive path for the SOC's `ftdi_rxd` pin, the counterpart of the existing UART emitter.
- Samples the asynchronous serial line, deserialises 8N1 frames and buffers received bytes in a small FIFO.
- The FIFO is drained by the IO-page read logic through a valid/ready pop interface.
- Sticky error flags are exposed for the IO status word.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate. Bit period `BIT_CYC = CLK_FREQ_HZ/BAUD_RATE` with integer truncation (217 at the defaults).
- FIFO_DEPTH, 8, number of receive FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- i_rx  in  1  raw serial line, asynchronous to clk; idles high.
- o_data  out  8  byte at the FIFO head.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  pop request; the head is consumed when o_valid & i_ready at a rising clk edge.
- o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky flag: a stop bit was sampled low.
- i_clear_err  in  1  synchronous clear of both sticky flags.
- o_busy  out  1  receiver FSM not in IDLE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - Outputs: o_valid=0, o_count=0, o_data=0, o_overrun=0, o_frame_err=0, o_busy=0.
  - Synchronizer flops reset to 1, so the line reads as idle.
- Input sync:
  - i_rx passes through 2 flops, giving rx_s; one more flop gives rx_d.
  - Falling edge is `rx_d & !rx_s`.
- Baud counter:
  - Loads on FSM transitions and decrements every cycle.
  - A sample event occurs when the counter reaches 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a falling edge, load the counter with `BIT_CYC/2 - 1` (107) and go to START.
  - START, at the sample event:
    - If rx_s=0, go to DATA: load `BIT_CYC-1` and set the bit index to 0.
    - Else it is a glitch: return to IDLE and push nothing.
  - DATA:
    - At each sample event, shift rx_s into the MSB of the shift register (LSB-first line order) and reload `BIT_CYC-1`.
    - After the 8th bit, go to STOP.
  - STOP, at the sample event:
    - If rx_s=1, push the byte and go to IDLE.
    - If rx_s=0, set o_frame_err, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A line held low (break) yields exactly one frame error.
- Push behaviour:
  - If the FIFO is full, the byte is dropped and o_overrun is set; FIFO contents are unchanged.
  - A simultaneous push and pop on a full FIFO is accepted: the pop frees a slot and the count is unchanged.
- Latency: o_valid rises 1 cycle after the STOP sample event.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Count is tracked separately so full and empty are unambiguous.
  - o_data is the combinational read of mem[rd_ptr]. It is undefined-but-stable while o_valid=0 and is required to be 0 only after reset.
  - A pop on an empty FIFO is ignored, i.e. i_ready with o_valid=0 has no effect.
  - Simultaneous push and pop on an empty FIFO: the count goes to 1 and the byte is not lost.
- Error flags:
  - i_clear_err clears both flags.
  - If clear and set occur in the same cycle, set wins.
- o_busy = (state != IDLE).
- Break during DATA: the byte is completed with zero bits, then the stop sample sees 0, which raises o_frame_err and enters WAIT_IDLE.

Decomposition:
- Package `uart_pkg`:
  - FSM state encoding (3-bit localparams).
  - Divisor computation function `bit_cycles(clk, baud)`.
- Sub-module `sync_fifo`:
  - Parameterised by WIDTH=8 and DEPTH.
  - Ports: push, push_data, pop, data, valid, full, count.
  - Reusable by a later UART TX buffer.
- The top level holds the synchronizer, baud counter, FSM and error flags.

Test Plan:
1. Drive byte 0x55 at 217 cycles/bit with the correct stop bit -> o_valid rises 1 cycle after the stop sample; o_data=0x55, o_count=1; popping once with i_ready -> o_valid=0.
2. Send 9 consecutive bytes 0x01..0x09 without popping, FIFO_DEPTH=8 -> o_count=8, o_overrun=1; pop order is 0x01..0x08 and 0x09 is lost; i_clear_err -> o_overrun=0.
3. Send 0xA3 with the stop bit driven 0, then hold the line low for 5 bit times -> o_frame_err=1 exactly once, o_count=0, FSM sits in WAIT_IDLE until the line returns high; a following 0x3C is received correctly.
4. Apply a low glitch of 50 cycles on an idle line -> no push, FSM returns to IDLE, o_busy low again within 108 cycles.
5. Assert resetn=0 mid-frame (during bit 4) with 3 bytes buffered -> o_count=0, o_valid=0, o_busy=0 immediately; the next full frame 0xF0 is received correctly.
6. With the FIFO full, pop in the same cycle as a push of 0x7E -> o_count stays 8, no overrun; 0x7E is read last.
